// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the OP encodings, the control FSM state encoding, default widths
// and small decode helpers used by the datapath.
package mdu_pkg;

  localparam int DWL_DEF = 32;
  localparam int CWL_DEF = 6;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Upper OP bit selects divide, lower bit selects signed arithmetic.
  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Conditional two's-complement negate.
// Ports:
//   a_i   - W-bit input value
//   neg_i - when high the output is -a_i, otherwise a_i
//   y_o   - W-bit result
// The most-negative input maps to itself, which is exactly the unsigned
// magnitude the datapath expects.
module mdu_cond_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);

  assign y_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit (MULTU, MULT, DIVU, DIV).
// Ports:
//   CLK   - clock, all state changes on the rising edge
//   RST   - synchronous active-high reset
//   START - operation request, honoured only in IDLE or DONE
//   OP    - operation select, captured with START
//   SRCA  - multiplicand / dividend, captured with START
//   SRCB  - multiplier / divisor, captured with START
//   BUSY  - high while iterating or sign-fixing
//   DONE  - one-cycle pulse, HI/LO valid from this cycle
//   DIVZ  - divide-by-zero flag, held until the next accepted START
//   HI    - product upper word / remainder
//   LO    - product lower word / quotient
// Operands are reduced to magnitudes at capture, iterated for DWL cycles,
// then sign-corrected in FIX and written to HI/LO on the FIX->DONE edge.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int DWL = DWL_DEF,
  parameter int CWL = CWL_DEF
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic [1:0]     OP,
  input  logic [DWL-1:0] SRCA,
  input  logic [DWL-1:0] SRCB,
  output logic           BUSY,
  output logic           DONE,
  output logic           DIVZ,
  output logic [DWL-1:0] HI,
  output logic [DWL-1:0] LO
);

  state_e             state_q, state_d;
  logic [CWL-1:0]     cnt_q, cnt_d;
  op_e                op_q, op_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend / growing quotient}.
  logic [2*DWL-1:0]   acc_q, acc_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [DWL-1:0]     opnd_q, opnd_d;
  logic               nres_q, nres_d;
  logic               nrem_q, nrem_d;
  logic [DWL-1:0]     hi_q, hi_d;
  logic [DWL-1:0]     lo_q, lo_d;
  logic               divz_q, divz_d;

  op_e                op_in_s;
  logic               sgn_a_s, sgn_b_s;
  logic [DWL-1:0]     mag_a_s, mag_b_s;
  logic               div0_s;
  logic [DWL:0]       mul_sum_s;
  logic [DWL:0]       div_trial_s;
  logic [DWL:0]       div_diff_s;
  logic [2*DWL-1:0]   prod_fix_s;
  logic [DWL-1:0]     quo_fix_s, rem_fix_s;

  assign op_in_s = op_e'(OP);
  assign sgn_a_s = op_is_signed(op_in_s) & SRCA[DWL-1];
  assign sgn_b_s = op_is_signed(op_in_s) & SRCB[DWL-1];
  assign div0_s  = op_is_div(op_in_s) && (SRCB == {DWL{1'b0}});

  mdu_cond_neg #(.W(DWL)) u_mag_a (.a_i(SRCA), .neg_i(sgn_a_s), .y_o(mag_a_s));
  mdu_cond_neg #(.W(DWL)) u_mag_b (.a_i(SRCB), .neg_i(sgn_b_s), .y_o(mag_b_s));

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit (acc LSB) is set; the carry lands in bit DWL.
  assign mul_sum_s = {1'b0, acc_q[2*DWL-1:DWL]}
                   + {1'b0, (acc_q[0] ? opnd_q : {DWL{1'b0}})};

  // Restoring step: remainder shifted left with the next dividend bit.
  // The remainder stays below the divisor, so DWL+1 bits never overflow.
  assign div_trial_s = acc_q[2*DWL-1:DWL-1];
  assign div_diff_s  = div_trial_s - {1'b0, opnd_q};

  mdu_cond_neg #(.W(2*DWL)) u_fix_prod (.a_i(acc_q), .neg_i(nres_q), .y_o(prod_fix_s));
  mdu_cond_neg #(.W(DWL)) u_fix_quo (.a_i(acc_q[DWL-1:0]), .neg_i(nres_q), .y_o(quo_fix_s));
  mdu_cond_neg #(.W(DWL)) u_fix_rem (.a_i(acc_q[2*DWL-1:DWL]), .neg_i(nrem_q), .y_o(rem_fix_s));

  // Next-state and datapath update logic for all registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    nres_d  = nres_q;
    nrem_d  = nrem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    divz_d  = divz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          op_d   = op_in_s;
          nres_d = sgn_a_s ^ sgn_b_s;
          nrem_d = sgn_a_s;
          cnt_d  = {CWL{1'b0}};
          divz_d = 1'b0;
          if (div0_s) begin
            // Short path: result is defined directly, no iteration.
            state_d = S_DONE;
            hi_d    = SRCA;
            lo_d    = {DWL{1'b1}};
            divz_d  = 1'b1;
          end else if (op_is_div(op_in_s)) begin
            state_d = S_RUN;
            acc_d   = {{DWL{1'b0}}, mag_a_s};
            opnd_d  = mag_b_s;
          end else begin
            state_d = S_RUN;
            acc_d   = {{DWL{1'b0}}, mag_b_s};
            opnd_d  = mag_a_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (op_is_div(op_q)) begin
          if (div_diff_s[DWL] == 1'b0) begin
            acc_d = {div_diff_s[DWL-1:0], acc_q[DWL-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[2*DWL-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum_s, acc_q[DWL-1:1]};
        end
        if (cnt_q == CWL'(DWL - 1)) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CWL'(1);
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        if (op_is_div(op_q)) begin
          hi_d = rem_fix_s;
          lo_d = quo_fix_s;
        end else begin
          hi_d = prod_fix_s[2*DWL-1:DWL];
          lo_d = prod_fix_s[DWL-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= {CWL{1'b0}};
      op_q    <= OP_MULTU;
      acc_q   <= {(2*DWL){1'b0}};
      opnd_q  <= {DWL{1'b0}};
      nres_q  <= 1'b0;
      nrem_q  <= 1'b0;
      hi_q    <= {DWL{1'b0}};
      lo_q    <= {DWL{1'b0}};
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      nres_q  <= nres_d;
      nrem_q  <= nrem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      divz_q  <= divz_d;
    end
  end

  assign BUSY = (state_q == S_RUN) || (state_q == S_FIX);
  assign DONE = (state_q == S_DONE);
  assign DIVZ = divz_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the multicycle datapath.
- Consumes the register-file read data (RFRD1 as SRCA, RFRD2 as SRCB) and computes MULT/MULTU/DIV/DIVU over DWL iterations.
- Results are held in internal HI/LO registers. The control FSM stalls on BUSY and later moves HI/LO back to the register-file write-data path (MFHI/MFLO).

Parameters:
- DWL, 32, operand/result word width; must be a power of two ≥ 8.
- CWL, 6, iteration counter width; must satisfy 2^CWL > DWL.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- START  input  1  request; sampled only in IDLE or DONE state.
- OP  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; captured with START.
- SRCA  input  DWL  multiplicand/dividend; captured with START.
- SRCB  input  DWL  multiplier/divisor; captured with START.
- BUSY  output  1  high in RUN and FIX states.
- DONE  output  1  one-cycle pulse; HI/LO valid from this cycle.
- DIVZ  output  1  set with DONE when a divide had SRCB==0; held until next accepted START.
- HI  output  DWL  product upper word / remainder.
- LO  output  DWL  product lower word / quotient.

Behaviour:
- Clocking and reset: one clock, CLK; reset RST is synchronous and active-high.
- Reset (any state, including mid-operation): state=IDLE, HI=0, LO=0, BUSY=0, DONE=0, DIVZ=0, counter=0. Any in-flight operation is discarded.
- States: IDLE, RUN, FIX, DONE.
  - IDLE: START=1 latches OP, SRCA, SRCB and clears DIVZ.
    - If a divide has SRCB==0, next state is DONE.
    - Otherwise next state is RUN with counter=0.
  - RUN: one radix-2 step per cycle.
    - Multiply: shift-add.
    - Divide: restoring shift-subtract.
    - Both operate on magnitudes. Signed ops take the two's-complement absolute value at capture; unsigned ops use operands unmodified.
    - After DWL steps (counter==DWL-1), next state is FIX.
  - FIX: apply sign correction, then write HI/LO at the FIX→DONE edge.
    - MULT: negate the 2·DWL-bit product if operand signs differ.
    - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - DONE: DONE=1 for exactly one cycle, BUSY=0.
    - START=1 here is accepted exactly as in IDLE (back-to-back ops).
    - Otherwise next state is IDLE.
- Latency: START high in cycle 0 → BUSY in cycles 1..DWL+1 → DONE in cycle DWL+2 (34 for DWL=32).
  - Divide-by-zero short path: DONE in cycle 1.
- START while BUSY is ignored; no queuing. SRCA/SRCB/OP changes after capture have no effect.
- HI/LO hold their value until the next DONE or reset. They never change during RUN/FIX, so stale values stay readable.
- Divide by zero: LO = all ones, HI = SRCA (unmodified), DIVZ=1. This applies to both DIV and DIVU.
- Signed overflow (DIV most-negative / -1): LO = 1 followed by DWL-1 zeros, HI = 0. This falls out of magnitude arithmetic; no special case.
- Arithmetic widths:
  - Product accumulator is 2·DWL bits.
  - Divider partial remainder is DWL+1 bits.
  - Magnitude of the most-negative value is treated as an unsigned DWL-bit value.

Decomposition:
- Shared package mdu_pkg holds:
  - OP encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - the state enum (S_IDLE, S_RUN, S_FIX, S_DONE);
  - DWL default.
- One natural sub-module: mdu_cond_neg, a parameterised conditional two's-complement negate.
  - Used for operand magnitudes and result sign fix.
- FSM, counter and shift datapath stay in mdu_iter.

Test Plan:
- MULTU SRCA=0xFFFFFFFF, SRCB=0xFFFFFFFF → DONE in cycle 34; HI=0xFFFFFFFE, LO=0x00000001; BUSY high cycles 1..33.
- MULT SRCA=-3 (0xFFFFFFFD), SRCB=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Back-to-back START during DONE, DIVU 100/7 → LO=14, HI=2 in cycle 68.
- DIV SRCA=-7, SRCB=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0, DIVZ=0.
- DIVU SRCA=100, SRCB=0 → DONE in cycle 1, DIVZ=1, HI=100, LO=0xFFFFFFFF. Next valid START clears DIVZ.
- START pulsed in cycle 5 with different operands during a running MULTU 6×7 → ignored; result HI=0, LO=42.
- RST asserted in cycle 10 of a DIV → cycle 11: BUSY=0, DONE=0, HI=LO=0, state IDLE. DONE must never pulse for the aborted op.
